// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the fetch-stage branch predictor.
//   ctr_t            2-bit direction counter encodings (SNT/WNT/WT/ST)
//   CTR_RESET        counter value after reset (weakly not-taken)
//   CTR_ALLOC        counter value given to a freshly allocated entry
//   DEFAULT_RESET_PC default fetch address after reset
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t        CTR_RESET        = WNT;
  localparam ctr_t        CTR_ALLOC        = WT;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

endpackage

// File: rtl/btb_table.sv
// btb_table: direct-mapped branch target buffer with 2-bit direction counters.
// One combinational read port (lookup) and one synchronous write port (training).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rd_idx, rd_tag        lookup index/tag of the current fetch PC
//   rd_taken              lookup hit and counter predicts taken
//   rd_target             stored target of the indexed entry
//   wr_en                 training strobe
//   wr_idx, wr_tag        index/tag of the resolved branch
//   wr_taken, wr_target   resolved direction and target
module btb_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_taken,
  output logic [31:0]      rd_target,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_taken,
  input  logic [31:0]      wr_target
);

  logic             valid  [ENTRIES];
  logic [TAG_W-1:0] tagmem [ENTRIES];
  logic [31:0]      target [ENTRIES];
  ctr_t             ctr    [ENTRIES];

  logic             wr_hit;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

  // Lookup reads the arrays directly, so a same-cycle write is not seen
  // until the following cycle (read-before-write).
  assign rd_taken  = valid[rd_idx] && (tagmem[rd_idx] == rd_tag) && ctr[rd_idx][1];
  assign rd_target = target[rd_idx];

  assign wr_hit = valid[wr_idx] && (tagmem[wr_idx] == wr_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tagmem[i] <= '0;
        target[i] <= '0;
        ctr[i]    <= CTR_RESET;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        if (wr_taken) begin
          ctr[wr_idx]    <= sat_inc(ctr[wr_idx]);
          target[wr_idx] <= wr_target;
        end else begin
          ctr[wr_idx]    <= sat_dec(ctr[wr_idx]);
        end
      end else if (wr_taken) begin
        // Miss on a taken branch: evict whatever occupies the slot.
        valid[wr_idx]  <= 1'b1;
        tagmem[wr_idx] <= wr_tag;
        target[wr_idx] <= wr_target;
        ctr[wr_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: rtl/fetch_predict.sv
// fetch_predict: instruction-fetch stage with integrated BTB prediction.
// Ports:
//   CLK, RESET                clock, asynchronous active-low reset
//   STALL                     holds the PC (redirect still wins)
//   Instr_Addr_OUT            instruction-memory address (= PC)
//   Instr_Data_IN             instruction-memory read data
//   Instr1_IF, Instr_PC_IF,
//   Instr_PC_Plus4_IF         to the IF/ID register
//   Pred_Taken_IF,
//   Pred_Next_PC_IF           prediction for the instruction at PC
//   Redirect_Valid/_PC        misprediction redirect from EXE
//   Update_Valid/_PC/_Taken/
//   _Target                   predictor training from EXE
//   Mispredict_Count          number of redirect cycles since reset
module fetch_predict
  import bp_pkg::*;
#(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  output logic [31:0] Instr_Addr_OUT,
  input  logic [31:0] Instr_Data_IN,
  output logic [31:0] Instr1_IF,
  output logic [31:0] Instr_PC_IF,
  output logic [31:0] Instr_PC_Plus4_IF,
  output logic        Pred_Taken_IF,
  output logic [31:0] Pred_Next_PC_IF,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_PC,
  input  logic        Update_Valid,
  input  logic [31:0] Update_PC,
  input  logic        Update_Taken,
  input  logic [31:0] Update_Target,
  output logic [31:0] Mispredict_Count
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] btb_target;
  logic        btb_taken;
  logic [31:0] mispredict_cnt;

  // Update addresses are word-aligned by construction; their low bits carry no index/tag.
  logic unused_update_lsb;
  assign unused_update_lsb = ^Update_PC[1:0];

  btb_table #(
    .ENTRIES (BTB_ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_btb (
    .clk       (CLK),
    .rst_n     (RESET),
    .rd_idx    (pc[IDX_W+1:2]),
    .rd_tag    (pc[31:IDX_W+2]),
    .rd_taken  (btb_taken),
    .rd_target (btb_target),
    .wr_en     (Update_Valid),
    .wr_idx    (Update_PC[IDX_W+1:2]),
    .wr_tag    (Update_PC[31:IDX_W+2]),
    .wr_taken  (Update_Taken),
    .wr_target (Update_Target)
  );

  assign pc_plus4          = pc + 32'd4;
  assign Instr_Addr_OUT    = pc;
  assign Instr1_IF         = Instr_Data_IN;
  assign Instr_PC_IF       = pc;
  assign Instr_PC_Plus4_IF = pc_plus4;
  assign Pred_Taken_IF     = btb_taken;
  assign Pred_Next_PC_IF   = btb_taken ? btb_target : pc_plus4;
  assign Mispredict_Count  = mispredict_cnt;

  // Redirect beats stall: a misprediction must flush even a frozen front end.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc             <= RESET_PC;
      mispredict_cnt <= '0;
    end else begin
      if (Redirect_Valid) begin
        pc             <= Redirect_PC;
        mispredict_cnt <= mispredict_cnt + 32'd1;
      end else if (!STALL) begin
        pc <= Pred_Next_PC_IF;
      end
    end
  end

endmodule

// File: tb/tb_fetch_predict.sv
// tb_fetch_predict: bench for fetch_predict (16-entry BTB, default reset PC).
// Random traffic is checked against a behavioural model of the predictor;
// a table of hand-computed vectors covers reset, stall, allocation,
// counter saturation, redirect priority, aliasing and PC wrap.
module tb_fetch_predict;

  localparam logic [31:0] B = 32'hBFC0_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        STALL = 1'b0;
  logic        Redirect_Valid = 1'b0;
  logic [31:0] Redirect_PC = '0;
  logic        Update_Valid = 1'b0;
  logic [31:0] Update_PC = '0;
  logic        Update_Taken = 1'b0;
  logic [31:0] Update_Target = '0;
  logic [31:0] Instr_Data_IN;
  logic [31:0] Instr_Addr_OUT;
  logic [31:0] Instr1_IF;
  logic [31:0] Instr_PC_IF;
  logic [31:0] Instr_PC_Plus4_IF;
  logic        Pred_Taken_IF;
  logic [31:0] Pred_Next_PC_IF;
  logic [31:0] Mispredict_Count;

  fetch_predict dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .STALL             (STALL),
    .Instr_Addr_OUT    (Instr_Addr_OUT),
    .Instr_Data_IN     (Instr_Data_IN),
    .Instr1_IF         (Instr1_IF),
    .Instr_PC_IF       (Instr_PC_IF),
    .Instr_PC_Plus4_IF (Instr_PC_Plus4_IF),
    .Pred_Taken_IF     (Pred_Taken_IF),
    .Pred_Next_PC_IF   (Pred_Next_PC_IF),
    .Redirect_Valid    (Redirect_Valid),
    .Redirect_PC       (Redirect_PC),
    .Update_Valid      (Update_Valid),
    .Update_PC         (Update_PC),
    .Update_Taken      (Update_Taken),
    .Update_Target     (Update_Target),
    .Mispredict_Count  (Mispredict_Count)
  );

  always #5 CLK = ~CLK;

  // Instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction
  assign Instr_Data_IN = imem(Instr_Addr_OUT);

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: each slot remembers the word address of the branch
  // that owns it, its target, and a 0..3 confidence level.
  bit          m_valid [16];
  logic [29:0] m_line  [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % 32'd16);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[slot(a)] && (m_line[slot(a)] == 30'(a >> 2));
  endfunction

  function automatic bit m_taken();
    return m_hit(m_pc) && (m_ctr[slot(m_pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_next();
    return m_taken() ? m_tgt[slot(m_pc)] : m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_line[i]  = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_pc  = B;
    m_cnt = '0;
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    int s;
    if (Redirect_Valid)  nxt = Redirect_PC;
    else if (STALL)      nxt = m_pc;
    else                 nxt = m_next();
    if (Redirect_Valid) m_cnt = m_cnt + 32'd1;
    if (Update_Valid) begin
      s = slot(Update_PC);
      if (m_hit(Update_PC)) begin
        if (Update_Taken) begin
          m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          m_tgt[s] = Update_Target;
        end else begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end
      end else if (Update_Taken) begin
        m_valid[s] = 1'b1;
        m_line[s]  = 30'(Update_PC >> 2);
        m_tgt[s]   = Update_Target;
        m_ctr[s]   = 2;
      end
    end
    m_pc = nxt;
  endtask

  task automatic check_model(input string nm);
    chk({nm, ".addr"},  Instr_Addr_OUT,          m_pc);
    chk({nm, ".pc"},    Instr_PC_IF,             m_pc);
    chk({nm, ".pc4"},   Instr_PC_Plus4_IF,       m_pc + 32'd4);
    chk({nm, ".instr"}, Instr1_IF,               imem(m_pc));
    chk({nm, ".taken"}, {31'd0, Pred_Taken_IF},  {31'd0, m_taken()});
    chk({nm, ".next"},  Pred_Next_PC_IF,         m_next());
    chk({nm, ".cnt"},   Mispredict_Count,        m_cnt);
  endtask

  task automatic step(input string nm);
    @(negedge CLK);
    check_model(nm);
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    STALL = 1'b0; Redirect_Valid = 1'b0; Redirect_PC = '0;
    Update_Valid = 1'b0; Update_PC = '0; Update_Taken = 1'b0; Update_Target = '0;
  endtask

  function automatic logic [31:0] pool_pc();
    logic [31:0] base;
    base = ($urandom_range(0, 1) != 0) ? 32'h0000_1400 : 32'h0000_1000;
    return base + 32'(4 * $urandom_range(0, 31));
  endfunction

  typedef struct {
    bit          stall;
    bit          rv;
    logic [31:0] rpc;
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utgt;
    logic [31:0] e_pc;
    bit          e_tk;
    logic [31:0] e_nxt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tv[$];

  task automatic addv(input bit stall, input bit rv, input logic [31:0] rpc,
                      input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utgt, input logic [31:0] e_pc,
                      input bit e_tk, input logic [31:0] e_nxt, input logic [31:0] e_cnt);
    vec_t v;
    v = '{stall, rv, rpc, uv, upc, ut, utgt, e_pc, e_tk, e_nxt, e_cnt};
    tv.push_back(v);
  endtask

  initial begin
    // Rows: stall, redirect, redirect pc, update, update pc, taken, target | pc, taken, next, count
    addv(0,0,0,      0,0,0,0,             B+'h00, 0, B+'h04, 0);
    addv(0,0,0,      0,0,0,0,             B+'h04, 0, B+'h08, 0);
    addv(0,0,0,      0,0,0,0,             B+'h08, 0, B+'h0C, 0);
    addv(0,0,0,      0,0,0,0,             B+'h0C, 0, B+'h10, 0);
    addv(1,0,0,      0,0,0,0,             B+'h10, 0, B+'h14, 0);
    addv(1,0,0,      0,0,0,0,             B+'h10, 0, B+'h14, 0);
    addv(1,0,0,      0,0,0,0,             B+'h10, 0, B+'h14, 0);
    addv(0,0,0,      1,B+'h20,1,B+'h100,  B+'h10, 0, B+'h14, 0);
    addv(0,0,0,      0,0,0,0,             B+'h14, 0, B+'h18, 0);
    addv(0,0,0,      0,0,0,0,             B+'h18, 0, B+'h1C, 0);
    addv(0,0,0,      0,0,0,0,             B+'h1C, 0, B+'h20, 0);
    addv(0,0,0,      1,B+'h20,0,0,        B+'h20, 1, B+'h100, 0);
    addv(0,0,0,      1,B+'h20,0,0,        B+'h100,0, B+'h104, 0);
    addv(0,1,B+'h20, 0,0,0,0,             B+'h104,0, B+'h108, 0);
    addv(0,0,0,      1,B+'h20,1,B+'h100,  B+'h20, 0, B+'h24, 1);
    addv(0,0,0,      1,B+'h20,1,B+'h100,  B+'h24, 0, B+'h28, 1);
    addv(0,0,0,      1,B+'h20,1,B+'h100,  B+'h28, 0, B+'h2C, 1);
    addv(0,0,0,      1,B+'h20,1,B+'h100,  B+'h2C, 0, B+'h30, 1);
    addv(0,0,0,      1,B+'h20,1,B+'h100,  B+'h30, 0, B+'h34, 1);
    addv(0,0,0,      1,B+'h20,0,0,        B+'h34, 0, B+'h38, 1);
    addv(0,1,B+'h20, 0,0,0,0,             B+'h38, 0, B+'h3C, 1);
    addv(0,0,0,      0,0,0,0,             B+'h20, 1, B+'h100, 2);
    addv(1,1,B+'h200,0,0,0,0,             B+'h100,0, B+'h104, 2);
    addv(1,0,0,      0,0,0,0,             B+'h200,0, B+'h204, 3);
    addv(0,0,0,      0,0,0,0,             B+'h200,0, B+'h204, 3);
    addv(0,0,0,      0,0,0,0,             B+'h204,0, B+'h208, 3);
    addv(0,1,'h40,   1,'h40,1,'h1000,     B+'h208,0, B+'h20C, 3);
    addv(0,1,'h80,   0,0,0,0,             'h40,   1, 'h1000,  4);
    addv(0,1,'h40,   1,'h80,1,'h2000,     'h80,   0, 'h84,    5);
    addv(0,1,'h80,   0,0,0,0,             'h40,   0, 'h44,    6);
    addv(0,0,0,      0,0,0,0,             'h80,   1, 'h2000,  7);
    addv(0,0,0,      0,0,0,0,             'h2000, 0, 'h2004,  7);
    addv(0,1,32'hFFFF_FFFC, 0,0,0,0,      'h2004, 0, 'h2008,  7);
    addv(0,0,0,      0,0,0,0,             32'hFFFF_FFFC, 0, 32'h0, 8);
    addv(0,0,0,      0,0,0,0,             32'h0,  0, 32'h4,   8);

    // Power-on reset.
    model_reset();
    idle_inputs();
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    step("por");

    // Randomized traffic around two aliasing 128-byte regions.
    for (int i = 0; i < 2000; i++) begin
      STALL          = ($urandom_range(0, 3) == 0);
      Redirect_Valid = (i == 0) || ($urandom_range(0, 7) == 0);
      Redirect_PC    = pool_pc();
      Update_Valid   = ($urandom_range(0, 1) != 0);
      Update_PC      = ($urandom_range(0, 1) != 0) ? m_pc : pool_pc();
      Update_Taken   = ($urandom_range(0, 4) < 3);
      Update_Target  = pool_pc();
      step("rnd");
    end

    // Reset asserted mid-run: state clears at once and holds across an edge.
    idle_inputs();
    RESET = 1'b0;
    #1;
    chk("rst.async.pc",    Instr_Addr_OUT, B);
    chk("rst.async.taken", {31'd0, Pred_Taken_IF}, 32'd0);
    chk("rst.async.cnt",   Mispredict_Count, 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    chk("rst.held.pc",  Instr_Addr_OUT, B);
    chk("rst.held.pc4", Instr_PC_Plus4_IF, B + 32'd4);
    chk("rst.held.cnt", Mispredict_Count, 32'd0);
    RESET = 1'b1;

    // Directed vectors.
    for (int r = 0; r < tv.size(); r++) begin
      STALL          = tv[r].stall;
      Redirect_Valid = tv[r].rv;
      Redirect_PC    = tv[r].rpc;
      Update_Valid   = tv[r].uv;
      Update_PC      = tv[r].upc;
      Update_Taken   = tv[r].ut;
      Update_Target  = tv[r].utgt;
      @(negedge CLK);
      chk($sformatf("tv%0d.pc", r),    Instr_PC_IF, tv[r].e_pc);
      chk($sformatf("tv%0d.pc4", r),   Instr_PC_Plus4_IF, tv[r].e_pc + 32'd4);
      chk($sformatf("tv%0d.taken", r), {31'd0, Pred_Taken_IF}, {31'd0, tv[r].e_tk});
      chk($sformatf("tv%0d.next", r),  Pred_Next_PC_IF, tv[r].e_nxt);
      chk($sformatf("tv%0d.cnt", r),   Mispredict_Count, tv[r].e_cnt);
      check_model($sformatf("tv%0d.m", r));
      model_step();
      @(posedge CLK);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
